// File: rtl/axi_mux_n_pkg.sv
// axi_mux_pkg: shared types for the N-port AXI master multiplexer.
//   w_state_t  : write-channel lock FSM states
//   axi_req_t  : master->slave signals of one AXI port (AW, W, AR, R/B ready)
//   axi_rsp_t  : slave->master signals of one AXI port (readies, R, B)
//   port_of_id : extracts the port-index field from an AXI ID
package axi_mux_pkg;

  localparam int ID_W   = 16;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int DATA_W = 512;
  localparam int STRB_W = 64;
  localparam int PW_MAX = 4;  // up to 16 ports

  typedef enum logic {W_IDLE = 1'b0, W_BURST = 1'b1} w_state_t;

  typedef struct packed {
    logic              aw_valid;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [LEN_W-1:0]  aw_len;
    logic [SIZE_W-1:0] aw_size;
    logic              w_valid;
    logic [ID_W-1:0]   w_id;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;
    logic              ar_valid;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic [SIZE_W-1:0] ar_size;
    logic              r_ready;
    logic              b_ready;
  } axi_req_t;

  typedef struct packed {
    logic              aw_ready;
    logic              w_ready;
    logic              ar_ready;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              b_valid;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
  } axi_rsp_t;

  function automatic logic [PW_MAX-1:0] port_of_id(input logic [ID_W-1:0] id,
                                                    input int id_lsb, input int pw);
    logic [ID_W-1:0] sh;
    sh = id >> id_lsb;
    return sh[PW_MAX-1:0] & PW_MAX'((1 << pw) - 1);
  endfunction

endpackage

// File: rtl/axi_mux_n_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with grant hold.
//   clk, rstn : clock, async active-low reset
//   req       : per-port requests
//   hold      : current grant was offered but not taken; keep it next cycle
//   advance   : grant taken; next search starts after grant_idx
//   grant     : one-hot grant, grant_idx : its index
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          hold,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr, held_idx, cand;
  logic          held, found;

  always_comb begin
    grant     = '0;
    grant_idx = held_idx;
    cand      = '0;
    found     = 1'b0;
    if (held) begin
      // payload must not change mid-handshake: no re-arbitration
      if (req[held_idx]) grant = N'(1) << held_idx;
    end else begin
      grant_idx = ptr;
      for (int i = 0; i < N; i++) begin
        cand = IW'((int'(ptr) + i) % N);
        if (!found && req[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
          grant     = N'(1) << cand;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= '0;
      held     <= 1'b0;
      held_idx <= '0;
    end else begin
      held     <= hold;
      held_idx <= grant_idx;
      if (advance) ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_mux_n.sv
// axi_mux_n: merges N_PORTS upstream AXI masters onto one downstream bus.
//   clk, rstn : clock, async active-low reset
//   in_req    : upstream master requests (IDs carry port index at ID_LSB)
//   in_rsp    : responses/readies back to each upstream master
//   out_req   : downstream request bundle
//   out_rsp   : downstream response bundle
//   stats     : per port {aw_grants, ar_grants}; built only when
//               AXI_MUX_N_STATS_EN is defined, otherwise tied to 0
// All forwarding is combinational; only arbiter pointers, the write lock
// FSM and the outstanding counters are registered.
module axi_mux_n
  import axi_mux_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int ID_LSB          = 0,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  axi_req_t [N_PORTS-1:0]      in_req,
  output axi_rsp_t [N_PORTS-1:0]      in_rsp,
  output axi_req_t                    out_req,
  input  axi_rsp_t                    out_rsp,
  output logic [N_PORTS-1:0][63:0]    stats
);

  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [N_PORTS-1:0][CW-1:0] rd_cnt, wr_cnt;
  w_state_t                   w_state;
  logic [PW-1:0]              lock, ar_idx, aw_idx, w_idx;
  logic [N_PORTS-1:0]         ar_req, aw_req, ar_gnt, aw_gnt;
  logic [N_PORTS-1:0]         rd_inc, rd_dec, wr_inc, wr_dec;
  logic ar_any, aw_any, ar_hs, aw_hs, w_ok, w_hs, r_hs, b_hs;
  int   r_p, b_p;

  always_comb begin
    ar_req = '0;
    aw_req = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      ar_req[p] = in_req[p].ar_valid && (rd_cnt[p] < CNT_MAX);
      aw_req[p] = in_req[p].aw_valid && (wr_cnt[p] < CNT_MAX) && (w_state == W_IDLE);
    end
  end

  rr_arbiter #(.N(N_PORTS)) u_ar_arb (
    .clk(clk), .rstn(rstn), .req(ar_req), .hold(ar_any & ~out_rsp.ar_ready),
    .advance(ar_hs), .grant(ar_gnt), .grant_idx(ar_idx)
  );

  rr_arbiter #(.N(N_PORTS)) u_aw_arb (
    .clk(clk), .rstn(rstn), .req(aw_req), .hold(aw_any & ~out_rsp.aw_ready),
    .advance(aw_hs), .grant(aw_gnt), .grant_idx(aw_idx)
  );

  assign ar_any = |ar_gnt;
  assign aw_any = |aw_gnt;
  assign ar_hs  = ar_any & out_rsp.ar_ready;
  assign aw_hs  = aw_any & out_rsp.aw_ready;
  // In W_IDLE, W follows the AW grant so W order always matches AW order.
  assign w_idx  = (w_state == W_BURST) ? lock : aw_idx;
  assign w_ok   = (w_state == W_BURST) | aw_any;
  assign w_hs   = out_req.w_valid & out_rsp.w_ready;
  assign r_hs   = out_rsp.r_valid & out_req.r_ready;
  assign b_hs   = out_rsp.b_valid & out_req.b_ready;
  assign r_p    = int'(port_of_id(out_rsp.r_id, ID_LSB, PW));
  assign b_p    = int'(port_of_id(out_rsp.b_id, ID_LSB, PW));

  always_comb begin
    out_req          = '0;
    out_req.ar_valid = ar_any;
    out_req.ar_id    = in_req[ar_idx].ar_id;
    out_req.ar_addr  = in_req[ar_idx].ar_addr;
    out_req.ar_len   = in_req[ar_idx].ar_len;
    out_req.ar_size  = in_req[ar_idx].ar_size;
    out_req.aw_valid = aw_any;
    out_req.aw_id    = in_req[aw_idx].aw_id;
    out_req.aw_addr  = in_req[aw_idx].aw_addr;
    out_req.aw_len   = in_req[aw_idx].aw_len;
    out_req.aw_size  = in_req[aw_idx].aw_size;
    out_req.w_valid  = w_ok & in_req[w_idx].w_valid;
    out_req.w_id     = in_req[w_idx].w_id;
    out_req.w_data   = in_req[w_idx].w_data;
    out_req.w_strb   = in_req[w_idx].w_strb;
    out_req.w_last   = in_req[w_idx].w_last;
    // responses addressed to a non-existent port are sunk
    out_req.r_ready  = 1'b1;
    out_req.b_ready  = 1'b1;
    for (int p = 0; p < N_PORTS; p++) begin
      if (p == r_p) out_req.r_ready = in_req[p].r_ready;
      if (p == b_p) out_req.b_ready = in_req[p].b_ready;
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      in_rsp[p]          = out_rsp;  // R/B payloads broadcast
      in_rsp[p].ar_ready = ar_gnt[p] & out_rsp.ar_ready;
      in_rsp[p].aw_ready = aw_gnt[p] & out_rsp.aw_ready;
      in_rsp[p].w_ready  = w_ok && (int'(w_idx) == p) && out_rsp.w_ready;
      in_rsp[p].r_valid  = out_rsp.r_valid && (r_p == p);
      in_rsp[p].b_valid  = out_rsp.b_valid && (b_p == p);
    end
  end

  always_comb begin
    rd_inc = '0; rd_dec = '0; wr_inc = '0; wr_dec = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rd_inc[p] = ar_hs && (int'(ar_idx) == p);
      rd_dec[p] = r_hs && out_rsp.r_last && (r_p == p) && (rd_cnt[p] != '0);
      wr_inc[p] = aw_hs && (int'(aw_idx) == p);
      wr_dec[p] = b_hs && (b_p == p) && (wr_cnt[p] != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (rd_inc[p] && !rd_dec[p])      rd_cnt[p] <= rd_cnt[p] + 1'b1;
        else if (rd_dec[p] && !rd_inc[p]) rd_cnt[p] <= rd_cnt[p] - 1'b1;
        if (wr_inc[p] && !wr_dec[p])      wr_cnt[p] <= wr_cnt[p] + 1'b1;
        else if (wr_dec[p] && !wr_inc[p]) wr_cnt[p] <= wr_cnt[p] - 1'b1;
      end
    end
  end

  // Write lock: an AW accepted without its last W beat pins W to that port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      lock    <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs && !(w_hs && out_req.w_last)) begin
          w_state <= W_BURST;
          lock    <= aw_idx;
        end
        W_BURST: if (w_hs && out_req.w_last) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

`ifdef AXI_MUX_N_STATS_EN
  logic [N_PORTS-1:0][31:0] aw_st, ar_st;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_st <= '0;
      ar_st <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (wr_inc[p] && (aw_st[p] != '1)) aw_st[p] <= aw_st[p] + 1'b1;
        if (rd_inc[p] && (ar_st[p] != '1)) ar_st[p] <= ar_st[p] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) stats[p] = {aw_st[p], ar_st[p]};
  end
`else
  assign stats = '0;
`endif

endmodule

// File: tb/tb_axi_mux_n.sv
// tb_axi_mux_n: self-checking bench for axi_mux_n (3 ports, port field at
// ID bits [5:4], at most 2 outstanding per direction).
module tb_axi_mux_n;
  import axi_mux_pkg::*;

  localparam int N = 3, LSB = 4, MAXO = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  axi_req_t [N-1:0]   in_req;
  axi_rsp_t [N-1:0]   in_rsp;
  axi_req_t           out_req;
  axi_rsp_t           out_rsp;
  logic [N-1:0][63:0] stats;

  int checks = 0, failures = 0;

  axi_mux_n #(.N_PORTS(N), .ID_LSB(LSB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn), .in_req(in_req), .in_rsp(in_rsp),
    .out_req(out_req), .out_rsp(out_rsp), .stats(stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rid;  logic rv; logic [N-1:0] rrdy;
    logic [15:0] bid;  logic bv; logic [N-1:0] brdy;
    logic [N-1:0] exp_rv; logic exp_rr; logic [N-1:0] exp_bv; logic exp_br;
  } rt_vec_t;

  rt_vec_t tbl [5];

  // reference model state for the randomized read phase
  int          rd_out [N];
  bit          pend   [N];
  logic [63:0] paddr  [N];
  logic [15:0] pid    [N];
  int          ptr, hold_g, eg, rp;
  bit          rv, rl, exp_rr;
  logic [15:0] rid;
  logic [N-1:0] vec, exp_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_id(input int p, input int lo);
    return 16'((p << LSB) | (lo & 15));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_req  = '0;
    out_rsp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  function automatic logic [4:0] hs_bits(input axi_rsp_t r);
    return {r.aw_ready, r.w_ready, r.ar_ready, r.r_valid, r.b_valid};
  endfunction

  initial begin
    // ---- reset state ----
    idle_inputs();
    #2;
    chk("rst_out_valids", {59'd0, out_req.ar_valid, out_req.aw_valid, out_req.w_valid,
                           out_req.r_ready, out_req.b_ready}, 64'd0);
    for (int p = 0; p < N; p++) chk("rst_port_hs", 64'(hs_bits(in_rsp[p])), 64'd0);
    chk("rst_stats", 64'(|stats), 64'd0);
    chk("rst_rd_cnt", 64'(dut.rd_cnt), 64'd0);
    tick();
    rstn = 1'b1;

    // ---- response routing table ----
    tbl[0] = '{16'h0023, 1'b1, 3'b100, 16'h000F, 1'b1, 3'b001, 3'b100, 1'b1, 3'b001, 1'b1};
    tbl[1] = '{16'h0021, 1'b1, 3'b011, 16'h0012, 1'b1, 3'b101, 3'b100, 1'b0, 3'b010, 1'b0};
    tbl[2] = '{16'h0035, 1'b1, 3'b000, 16'h0030, 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1};
    tbl[3] = '{16'h0110, 1'b0, 3'b010, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0};
    tbl[4] = '{16'h0C05, 1'b1, 3'b110, 16'h0026, 1'b1, 3'b100, 3'b001, 1'b0, 3'b100, 1'b1};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      out_rsp.r_valid = tbl[i].rv;  out_rsp.r_id = tbl[i].rid;
      out_rsp.r_data  = 512'(64'hD000 + i);
      out_rsp.b_valid = tbl[i].bv;  out_rsp.b_id = tbl[i].bid;
      for (int p = 0; p < N; p++) begin
        in_req[p].r_ready = tbl[i].rrdy[p];
        in_req[p].b_ready = tbl[i].brdy[p];
      end
      #1;
      for (int p = 0; p < N; p++) begin
        vec[p]     = in_rsp[p].r_valid;
        exp_vec[p] = in_rsp[p].b_valid;
      end
      chk($sformatf("tbl%0d_rvalid", i), 64'(vec), 64'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_rready", i), 64'(out_req.r_ready), 64'(tbl[i].exp_rr));
      chk($sformatf("tbl%0d_bvalid", i), 64'(exp_vec), 64'(tbl[i].exp_bv));
      chk($sformatf("tbl%0d_bready", i), 64'(out_req.b_ready), 64'(tbl[i].exp_br));
      chk($sformatf("tbl%0d_rdata", i), in_rsp[i % N].r_data[63:0], 64'hD000 + 64'(i));
      tick();
    end

    // ---- round robin order and outstanding limit ----
    do_reset();
    for (int p = 0; p < N; p++) begin
      in_req[p].ar_valid = 1'b1;
      in_req[p].ar_id    = mk_id(p, 1);
      in_req[p].ar_addr  = 64'h1000 * 64'(p + 1);
    end
    out_rsp.ar_ready = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      #1;
      chk($sformatf("rr%0d_addr", c), out_req.ar_addr, 64'h1000 * 64'((c % N) + 1));
      chk($sformatf("rr%0d_ready", c), 64'(in_rsp[c % N].ar_ready), 64'd1);
      tick();
    end
    #1;
    chk("limit_arvalid", 64'(out_req.ar_valid), 64'd0);
    chk("limit_p0_ready", 64'(in_rsp[0].ar_ready), 64'd0);
    out_rsp.r_valid = 1'b1; out_rsp.r_id = mk_id(1, 7); out_rsp.r_last = 1'b1;
    in_req[1].r_ready = 1'b1;
    #1;
    chk("limit_rready", 64'(out_req.r_ready), 64'd1);
    chk("limit_same_cycle", 64'(out_req.ar_valid), 64'd0);
    tick();
    out_rsp.r_valid = 1'b0;
    #1;
    chk("limit_next_valid", 64'(out_req.ar_valid), 64'd1);
    chk("limit_next_addr", out_req.ar_addr, 64'h2000);

    // ---- grant hold while arready is low ----
    do_reset();
    in_req[2].ar_valid = 1'b1; in_req[2].ar_addr = 64'hABCD; in_req[2].ar_id = mk_id(2, 3);
    in_req[0].ar_addr  = 64'h5555; in_req[0].ar_id = mk_id(0, 3);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold%0d_addr", c), out_req.ar_addr, 64'hABCD);
      chk($sformatf("hold%0d_rdy0", c), 64'(in_rsp[0].ar_ready), 64'd0);
      tick();
      in_req[0].ar_valid = 1'b1;
    end
    out_rsp.ar_ready = 1'b1;
    #1;
    chk("hold_release_rdy2", 64'(in_rsp[2].ar_ready), 64'd1);
    tick();
    in_req[2].ar_valid = 1'b0;
    #1;
    chk("hold_after_addr", out_req.ar_addr, 64'h5555);

    // ---- write burst lock ----
    do_reset();
    out_rsp.aw_ready = 1'b1; out_rsp.w_ready = 1'b1;
    in_req[1].aw_valid = 1'b1; in_req[1].aw_id = mk_id(1, 3); in_req[1].aw_len = 8'd3;
    in_req[1].w_valid  = 1'b1; in_req[1].w_id  = mk_id(1, 3);
    in_req[1].w_data   = 512'(64'hB0); in_req[1].w_last = 1'b0;
    in_req[2].aw_valid = 1'b1; in_req[2].aw_id = mk_id(2, 1);
    in_req[2].w_valid  = 1'b1; in_req[2].w_id  = mk_id(2, 1); in_req[2].w_last = 1'b1;
    #1;
    chk("b0_awid", 64'(out_req.aw_id), 64'(mk_id(1, 3)));
    chk("b0_aw_rdy2", 64'(in_rsp[2].aw_ready), 64'd0);
    chk("b0_wid", 64'(out_req.w_id), 64'(mk_id(1, 3)));
    tick();
    in_req[1].aw_valid = 1'b0;
    for (int b = 1; b < 4; b++) begin
      in_req[1].w_data = 512'(64'hB0 + 64'(b));
      in_req[1].w_last = (b == 3);
      #1;
      chk($sformatf("b%0d_awvalid", b), 64'(out_req.aw_valid), 64'd0);
      chk($sformatf("b%0d_aw_rdy2", b), 64'(in_rsp[2].aw_ready), 64'd0);
      chk($sformatf("b%0d_wid", b), 64'(out_req.w_id), 64'(mk_id(1, 3)));
      chk($sformatf("b%0d_wdata", b), out_req.w_data[63:0], 64'hB0 + 64'(b));
      chk($sformatf("b%0d_w_rdy2", b), 64'(in_rsp[2].w_ready), 64'd0);
      tick();
    end
    in_req[1].w_valid = 1'b0;
    in_req[0].aw_valid = 1'b1; in_req[0].aw_id = mk_id(0, 9);
    in_req[0].w_valid  = 1'b1; in_req[0].w_id  = mk_id(0, 9); in_req[0].w_last = 1'b0;
    #1;
    chk("b4_aw_rdy2", 64'(in_rsp[2].aw_ready), 64'd1);
    chk("b4_wid", 64'(out_req.w_id), 64'(mk_id(2, 1)));
    tick();
    in_req[2] = '0;
    out_rsp.b_valid = 1'b1; out_rsp.b_id = mk_id(1, 3); in_req[1].b_ready = 1'b1;
    #1;
    chk("b5_aw_rdy0", 64'(in_rsp[0].aw_ready), 64'd1);
    chk("b5_bvalid1", 64'(in_rsp[1].b_valid), 64'd1);
    tick();
    out_rsp.b_valid = 1'b0;
    chk("b6_wr_cnt", 64'(dut.wr_cnt), 64'b01_00_01);
    chk("b6_state", 64'(dut.w_state), 64'(W_BURST));
    // asynchronous reset mid-burst, checked before the next clock edge
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_state", 64'(dut.w_state), 64'(W_IDLE));
    chk("arst_wr_cnt", 64'(dut.wr_cnt), 64'd0);
    chk("arst_rd_cnt", 64'(dut.rd_cnt), 64'd0);
    chk("arst_stats", 64'(|stats), 64'd0);

    // ---- randomized reads against the reference model ----
    do_reset();
    ptr = 0; hold_g = -1; rv = 0; rl = 0; rid = '0;
    for (int p = 0; p < N; p++) begin rd_out[p] = 0; pend[p] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]  = 1;
          paddr[p] = {$urandom, $urandom};
          pid[p]   = mk_id(p, int'($urandom_range(0, 15)));
        end
        in_req[p].ar_valid = pend[p];
        in_req[p].ar_addr  = paddr[p];
        in_req[p].ar_id    = pid[p];
        in_req[p].r_ready  = 1'($urandom_range(0, 1));
      end
      out_rsp.ar_ready = 1'($urandom_range(0, 1));
      if (!rv && $urandom_range(0, 1) == 1) begin
        rv  = 1;
        rid = mk_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        rl  = 1'($urandom_range(0, 1));
      end
      out_rsp.r_valid = rv; out_rsp.r_id = rid; out_rsp.r_last = rl;
      #1;
      eg = hold_g;
      if (eg < 0)
        for (int i = 0; i < N; i++)
          if (eg < 0 && pend[(ptr + i) % N] && rd_out[(ptr + i) % N] < MAXO) eg = (ptr + i) % N;
      chk("rnd_arvalid", 64'(out_req.ar_valid), 64'(eg >= 0));
      if (eg >= 0) begin
        chk("rnd_araddr", out_req.ar_addr, paddr[eg]);
        chk("rnd_arready", 64'(in_rsp[eg].ar_ready), 64'(out_rsp.ar_ready));
      end
      rp = (int'(rid) >> LSB) & 3;
      exp_rr = (rp < N) ? in_req[rp].r_ready : 1'b1;
      for (int p = 0; p < N; p++) begin
        vec[p]     = in_rsp[p].r_valid;
        exp_vec[p] = rv && (rp == p);
      end
      chk("rnd_rready", 64'(out_req.r_ready), 64'(exp_rr));
      chk("rnd_rvalid", 64'(vec), 64'(exp_vec));
      // model update for the coming clock edge
      if (eg >= 0 && out_rsp.ar_ready) begin
        rd_out[eg]++;
        ptr = (eg + 1) % N;
        pend[eg] = 0;
        hold_g = -1;
      end else hold_g = eg;
      if (rv && exp_rr) begin
        if (rl && rp < N && rd_out[rp] > 0) rd_out[rp]--;
        rv = 0;
      end
      tick();
    end
    for (int p = 0; p < N; p++)
      chk($sformatf("rnd_rd_cnt%0d", p), 64'(dut.rd_cnt[p]), 64'(rd_out[p]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mux_n.md
# axi_mux_n

N-port AXI master multiplexer with round-robin arbitration, burst-aware write locking, per-port outstanding-transaction limits and ID-based response routing. It merges N accelerator-side AXI masters onto one memory-side AXI bus in front of the DDR/PCIe interconnect. It replaces hard-wired two-port muxing with a generic N-port block. Any register staging is instantiated outside this block.

## Interface
- N_PORTS, 4: number of upstream masters, 2..16.
- ID_LSB, 0: LSB of the port-index field inside AXI IDs. Field width is PW = $clog2(N_PORTS).
- MAX_OUTSTANDING, 16: per-port limit on in-flight reads, and separately on in-flight writes.
- clk  in  1  clock; all logic is in this one domain.
- rstn  in  1  reset, asynchronous, active-low.
- in[N_PORTS]  axi_bus_t.master  array  upstream masters. Upstream IDs already carry the port index in id[ID_LSB +: PW].
- out  axi_bus_t.slave  bundle  downstream bus. Fields: 16b id, 64b addr, 8b len, 3b size, 512b data, 64b strb.
- stats  out  N_PORTS×64  per port, {aw_grants[31:0], ar_grants[31:0]}. Present only with the macro; see Configuration.

## Operation
- **AR arbiter**
  - Round-robin over ports with arvalid and rd_cnt[p] < MAX_OUTSTANDING.
  - After a grant to p, the search starts at p+1 mod N.
  - Once out.arvalid is asserted, the grant is held until out.arready. Payload never changes mid-handshake.
- **AW arbiter**: same round-robin and hold rules, with a separate pointer. Gated by wr_cnt[p] < MAX_OUTSTANDING and by the write FSM.
- **Write FSM**
  - W_IDLE
    - Granted port g drives AW.
    - out.wvalid = in[g].wvalid & in[g].awvalid. W beats are never accepted before or without their AW.
    - If AW and a wlast beat are accepted in the same cycle, stay in W_IDLE.
    - If AW is accepted without a wlast beat, go to W_BURST with lock = g.
  - W_BURST
    - out.awvalid = 0 and every in[*].awready = 0.
    - W is forwarded from port lock only.
    - On an accepted beat with wlast, return to W_IDLE.
  - W order therefore always matches AW order.
- **Ready routing**: in[p].Xready = out.Xready & (p is the selected port for channel X). Non-selected ports see ready = 0.
- **Response routing**
  - R destination is r_p = out.rid[ID_LSB +: PW]; out.rready = in[r_p].rready. B is routed the same way on bid.
  - R and B payloads are broadcast to all ports; valid goes only to the addressed port.
  - If the index is ≥ N_PORTS, force ready = 1 and drop the response. No port sees valid.
- **Counters**
  - rd_cnt[p]: +1 on an AR handshake from p; −1 on an R handshake with rlast routed to p.
  - wr_cnt[p]: +1 on an AW handshake; −1 on a B handshake.
  - Increment and decrement in the same cycle leave the count unchanged.
  - Width is $clog2(MAX_OUTSTANDING+1). Counts never wrap; a decrement at 0 is ignored.

## Timing
- Zero-cycle forwarding on all channels: outputs are combinational from the inputs and state.
- State updates on the clk edge.
- Reset state (asynchronous, immediate)
  - AR/AW pointers start at port 0.
  - Write FSM = W_IDLE; counters = 0; stats = 0.
  - With all inputs idle, every valid/ready output is 0.
- A lock release on wlast allows a new AW grant in the next cycle. Burst-to-burst gap: 1 cycle minimum when AW and the last W are split.
- A port at the limit becomes eligible in the cycle after its decrementing handshake.
- Reset asserted mid-burst abandons the lock and counters. Upstream and downstream are reset together.

## Configuration
- AXI_MUX_N_STATS_EN defined
  - Per-port 32-bit saturating counters of AW and AR handshakes, driven on stats.
  - Counters are cleared only by rstn.
- Undefined: counters are not built and stats is tied to 0.

## Structure
- Shared package axi_mux_pkg
  - Typedef w_state_t {W_IDLE, W_BURST}.
  - Function port_of_id(id, ID_LSB, PW).
- Sub-module rr_arbiter #(N)
  - Inputs: req[N], hold, advance.
  - Outputs: grant one-hot, grant_idx.
  - One instance each for AR and AW.

## Test plan
- Ports 0–3 assert arvalid every cycle with arready = 1 → AR grants in order 0,1,2,3,0…; 4 grants per port over 16 cycles.
- Port 1 AW (awlen = 3) with W beats at one per cycle; port 2 awvalid meanwhile → port 2 awready stays 0 until port 1's wlast handshake, and out.wid is never 2 during the burst.
- out.arready held 0 for 5 cycles while ports 0 and 3 request → out.araddr stable and grant unchanged throughout.
- MAX_OUTSTANDING = 2, port 0 issues 3 ARs, no R returned → third arready = 0. After one R with rlast to port 0, the third AR is accepted the following cycle.
- R with rid port field = 2, then B with bid field = 0 → only in[2].rvalid rises, then only in[0].bvalid. With N_PORTS = 3 and a field of 3 → out.rready = 1, no port valid.
- rstn pulled low mid-burst → FSM returns to W_IDLE and all counters read 0 without a clock edge. With AXI_MUX_N_STATS_EN, stats reads 0.
